accel_host_bridge: RTL and testbench

//  PicoRV32 native-memory-bus slave that drives the MNIST accelerator's host side.
//  CPU stores pixel words into an image buffer, kicks a run, polls status, then reads the class scores.

---
 rtl/accel_host_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_accel_host_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_host_bridge.sv
// rtl/accel_host_bridge.sv - PicoRV32 native-bus slave that loads, kicks and reads back the MNIST accelerator
// Optional feature: define ACCEL_ARGMAX_EN for the argmax-of-results register at offset 0x1040.
module accel_host_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int unsigned N_WORDS     = 785,
  parameter int unsigned N_CLASSES   = 10,
  parameter int unsigned KICK_CYCLES = 2,
  parameter logic [31:0] TIMEOUT     = 32'd200000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    mem_valid,
  input  logic [31:0]             mem_addr,
  input  logic [31:0]             mem_wdata,
  input  logic [3:0]              mem_wstrb,
  output logic                    mem_ready,
  output logic [31:0]             mem_rdata,
  output logic [N_WORDS*32-1:0]   accel_image,
  output logic                    accel_reset,
  input  logic                    accel_ready,
  input  logic [N_CLASSES*32-1:0] accel_results
);

  typedef enum logic [1:0] {S_IDLE, S_KICK, S_WAIT_LO, S_WAIT_HI} state_t;

  state_t                  r_state;
  logic                    r_mem_ready;
  logic [31:0]             r_mem_rdata;
  logic [31:0]             r_image [N_WORDS];
  logic [N_CLASSES*32-1:0] r_result;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic                    r_accel_reset;
  logic [31:0]             r_cnt;
  logic [7:0]              r_kick_cnt;

  logic        w_hit;
  logic        w_wr;
  logic [9:0]  w_idx;
  logic        w_img_ok;
  logic        w_res_ok;
  logic [3:0]  w_res_idx;
  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_clr;
  logic        w_timeout;
  logic [31:0] w_rd;
  logic [31:0] w_res [N_CLASSES];
  logic        w_unused;

  assign w_hit     = mem_valid && (mem_addr[31:13] == BASE_ADDR[31:13]) && !r_mem_ready;
  assign w_wr      = w_hit && (mem_wstrb != 4'b0000);
  assign w_idx     = mem_addr[11:2];
  assign w_img_ok  = !mem_addr[12] && ({22'd0, w_idx} < N_WORDS);
  assign w_res_ok  = mem_addr[12] && (w_idx >= 10'd4) && ({22'd0, w_idx} < N_CLASSES + 32'd4);
  assign w_res_idx = 4'(w_idx - 10'd4);
  assign w_ctrl_wr = w_wr && mem_addr[12] && (w_idx == 10'd0) && mem_wstrb[0];
  assign w_start   = w_ctrl_wr && mem_wdata[0];
  assign w_clr     = w_ctrl_wr && mem_wdata[1];
  assign w_timeout = (r_cnt == TIMEOUT);
  assign w_unused  = ^mem_addr[1:0];

  assign mem_ready   = r_mem_ready;
  assign mem_rdata   = r_mem_rdata;
  assign accel_reset = r_accel_reset;

  genvar gi;
  generate
    for (gi = 0; gi < N_WORDS; gi++) begin : g_img
      assign accel_image[gi*32 +: 32] = r_image[gi];
    end
    for (gi = 0; gi < N_CLASSES; gi++) begin : g_res
      assign w_res[gi] = r_result[gi*32 +: 32];
    end
  endgenerate

`ifdef ACCEL_ARGMAX_EN
  logic              r_am_pend;
  logic [3:0]        r_argmax;
  logic [3:0]        w_argmax;
  logic signed [31:0] w_best;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_argmax = 4'd0;
    w_best   = $signed(w_res[0]);
    for (int k = 1; k < int'(N_CLASSES); k++) begin
      if ($signed(w_res[4'(k)]) > w_best) begin
        w_best   = $signed(w_res[4'(k)]);
        w_argmax = 4'(k);
      end
    end
  end
`endif

  always_comb begin
    w_rd = 32'd0;
    if (w_img_ok) begin
      w_rd = r_image[w_idx];
    end else if (mem_addr[12] && (w_idx == 10'd1)) begin
      w_rd = {29'd0, r_err, r_done, r_busy};
    end else if (w_res_ok) begin
      w_rd = w_res[w_res_idx];
`ifdef ACCEL_ARGMAX_EN
    end else if (mem_addr[12] && (w_idx == 10'd16)) begin
      w_rd = {28'd0, r_argmax};
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_mem_ready   <= 1'b0;
      r_mem_rdata   <= 32'd0;
      r_image       <= '{default: 32'd0};
      r_result      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_accel_reset <= 1'b0;
      r_cnt         <= 32'd0;
      r_kick_cnt    <= 8'd0;
`ifdef ACCEL_ARGMAX_EN
      r_am_pend     <= 1'b0;
      r_argmax      <= 4'd0;
`endif
    end else begin
      r_mem_ready <= w_hit;
      r_mem_rdata <= (w_hit && (mem_wstrb == 4'b0000)) ? w_rd : 32'd0;

      // The accelerator samples the buffer during a run, so it is frozen while busy.
      if (w_wr && w_img_ok && !r_busy) begin
        if (mem_wstrb[0]) r_image[w_idx][7:0]   <= mem_wdata[7:0];
        if (mem_wstrb[1]) r_image[w_idx][15:8]  <= mem_wdata[15:8];
        if (mem_wstrb[2]) r_image[w_idx][23:16] <= mem_wdata[23:16];
        if (mem_wstrb[3]) r_image[w_idx][31:24] <= mem_wdata[31:24];
      end

      if (w_clr) r_err <= 1'b0;

`ifdef ACCEL_ARGMAX_EN
      if (r_am_pend) begin
        r_am_pend <= 1'b0;
        r_argmax  <= w_argmax;
        r_done    <= 1'b1;
      end
`endif

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state       <= S_KICK;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_cnt         <= 32'd0;
            r_kick_cnt    <= 8'd0;
            r_accel_reset <= 1'b1;
`ifdef ACCEL_ARGMAX_EN
            r_am_pend     <= 1'b0;
`endif
          end
        end
        S_KICK: begin
          if (r_kick_cnt == 8'(KICK_CYCLES - 1)) begin
            r_state       <= S_WAIT_LO;
            r_accel_reset <= 1'b0;
          end else begin
            r_kick_cnt <= r_kick_cnt + 8'd1;
          end
        end
        S_WAIT_LO: begin
          if (!accel_ready) begin
            r_state <= S_WAIT_HI;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end
          if (!w_timeout) r_cnt <= r_cnt + 32'd1;
        end
        S_WAIT_HI: begin
          if (accel_ready) begin
            r_state  <= S_IDLE;
            r_result <= accel_results;
            r_busy   <= 1'b0;
`ifdef ACCEL_ARGMAX_EN
            r_am_pend <= 1'b1;
`else
            r_done    <= 1'b1;
`endif
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end
          if (!w_timeout) r_cnt <= r_cnt + 32'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_host_bridge.sv
// tb/tb_accel_host_bridge.sv - randomized self-checking bench for accel_host_bridge
// Works with or without ACCEL_ARGMAX_EN defined.
module tb_accel_host_bridge;

  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam int NW   = 785;
  localparam int NC   = 10;
  localparam int KICK = 2;
  localparam int TMO  = 1000;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             mem_valid = 1'b0;
  logic [31:0]      mem_addr = 32'd0;
  logic [31:0]      mem_wdata = 32'd0;
  logic [3:0]       mem_wstrb = 4'd0;
  logic             mem_ready;
  logic [31:0]      mem_rdata;
  logic [NW*32-1:0] accel_image;
  logic             accel_reset;
  logic             accel_ready = 1'b1;
  logic [NC*32-1:0] accel_results = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  accel_host_bridge #(
    .BASE_ADDR(BASE), .N_WORDS(NW), .N_CLASSES(NC), .KICK_CYCLES(KICK), .TIMEOUT(32'(TMO))
  ) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .accel_image(accel_image), .accel_reset(accel_reset),
    .accel_ready(accel_ready), .accel_results(accel_results)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: image/result arrays plus run bookkeeping.
  logic [31:0] m_img [NW];
  logic [31:0] m_res [NC];
  bit          m_busy, m_done, m_err, m_seen_low, m_rdy, m_rd, m_pend;
  int          m_kick, m_wait, m_argmax;
  logic [31:0] m_rdata;

  function automatic int argmax_of_model();
    int best = 0;
    for (int k = 1; k < NC; k++)
      if ($signed(m_res[k]) > $signed(m_res[best])) best = k;
    return best;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int w = int'(a[11:2]);
    if (!a[12]) return (w < NW) ? m_img[w] : 32'd0;
    if (w == 1) return {29'd0, m_err, m_done, m_busy};
    if (w >= 4 && w < 4 + NC) return m_res[w - 4];
`ifdef ACCEL_ARGMAX_EN
    if (w == 16) return 32'(m_argmax);
`endif
    return 32'd0;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NW; i++) m_img[i] = 32'd0;
      for (int k = 0; k < NC; k++) m_res[k] = 32'd0;
      m_busy = 0; m_done = 0; m_err = 0; m_seen_low = 0; m_rdy = 0; m_rd = 0; m_pend = 0;
      m_kick = 0; m_wait = 0; m_argmax = 0; m_rdata = 32'd0;
    end else begin
      bit hit, was_busy;
      int w;
      was_busy = m_busy;
      w = int'(mem_addr[11:2]);
      hit = mem_valid && (mem_addr[31:13] == BASE[31:13]) && !m_rdy;
      m_rd = hit && (mem_wstrb == 4'd0);
      if (m_rd) m_rdata = model_read(mem_addr);
      m_rdy = hit;
      if (m_pend) begin
        m_pend = 0; m_done = 1; m_argmax = argmax_of_model();
      end
      if (hit && mem_wstrb != 4'd0) begin
        if (!mem_addr[12] && w < NW && !was_busy)
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) m_img[w][b*8 +: 8] = mem_wdata[b*8 +: 8];
        if (mem_addr[12] && w == 0 && mem_wstrb[0]) begin
          if (mem_wdata[1]) m_err = 0;
          if (mem_wdata[0] && !was_busy) begin
            m_busy = 1; m_done = 0; m_pend = 0; m_kick = KICK; m_wait = 0; m_seen_low = 0;
          end
        end
      end
      if (was_busy) begin
        if (m_kick > 0) begin
          m_kick--;
        end else begin
          if (!m_seen_low && !accel_ready) begin
            m_seen_low = 1;
          end else if (m_seen_low && accel_ready) begin
            for (int k = 0; k < NC; k++) m_res[k] = accel_results[k*32 +: 32];
            m_busy = 0;
`ifdef ACCEL_ARGMAX_EN
            m_pend = 1;
`else
            m_done = 1;
`endif
          end else if (m_wait == TMO) begin
            m_err = 1; m_busy = 0;
          end
          if (m_busy && m_wait < TMO) m_wait++;
        end
      end
    end
  end

  // Single compare process: outputs checked against the model every cycle.
  always @(negedge clk) begin
    int bad;
    bad = -1;
    for (int i = 0; i < NW; i++)
      if (bad < 0 && accel_image[i*32 +: 32] !== m_img[i]) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL accel_image word %0d: got %h expected %h at %0t", bad, accel_image[bad*32 +: 32], m_img[bad], $time);
    end
    chk("accel_reset", 32'(accel_reset), 32'(m_kick > 0));
    chk("mem_ready", 32'(mem_ready), 32'(m_rdy));
    if (m_rdy && m_rd) chk("mem_rdata", mem_rdata, m_rdata);
  end

  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input bit expect_ack, output logic [31:0] rdata);
    bit got;
    got = 0; rdata = 32'd0;
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    for (int t = 0; t < 6 && !got; t++) begin
      @(negedge clk);
      if (mem_ready) begin got = 1; rdata = mem_rdata; end
    end
    mem_valid = 1'b0; mem_wstrb = 4'd0;
    chk("bus_ack", 32'(got), 32'(expect_ack));
  endtask

  task automatic wr(input int off, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] d;
    bus(BASE + 32'(off), data, strb, 1'b1, d);
  endtask

  task automatic rd(input int off, output logic [31:0] data);
    bus(BASE + 32'(off), 32'd0, 4'd0, 1'b1, data);
  endtask

  task automatic poll(input logic [31:0] mask, input int budget, output logic [31:0] st);
    int t;
    t = 0; st = 32'd0;
    while (t < budget && (st & mask) == 32'd0) begin
      rd(32'h1004, st);
      t++;
    end
    chk("poll_budget", 32'((st & mask) != 32'd0), 32'd1);
  endtask

  // Accelerator stand-in: waits for the kick, drops ready, optionally raises it with scores.
  task automatic accel_run(input int drop, input int rise, input bit never, input logic [NC*32-1:0] scores);
    int t, cnt;
    t = 0; cnt = 0;
    while (accel_reset !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    while (accel_reset === 1'b1 && cnt < 50) begin cnt++; @(negedge clk); end
    chk("kick_len", 32'(cnt), 32'(KICK));
    repeat (drop) @(negedge clk);
    accel_ready = 1'b0;
    if (!never) begin
      repeat (rise) @(negedge clk);
      accel_results = scores;
      accel_ready = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [31:0] d;
    logic [NC*32-1:0] sc;
    int idx;

    repeat (3) @(negedge clk);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_accel_reset", 32'(accel_reset), 32'd0);
    #2 resetn = 1'b1;
    @(negedge clk);
    rd(32'h1004, d);
    chk("rst_status", d, 32'd0);

    wr(0, 32'h1234_5678, 4'b0011);
    rd(0, d);
    chk("strobe_word0", d, 32'h0000_5678);
    chk("image_port_word0", accel_image[31:0], 32'h0000_5678);

    wr(32'h1008, 32'hFFFF_FFFF, 4'hF);
    rd(32'h1008, d);
    chk("unmapped_reg", d, 32'd0);
    rd(4 * 817, d);
    chk("unmapped_img", d, 32'd0);
    bus(32'h0400_0000, 32'd0, 4'd0, 1'b0, d);

    for (int i = 0; i < NW; i++) wr(4 * i, $urandom, 4'hF);
    repeat (60) begin
      idx = $urandom_range(0, NW - 1);
      if ($urandom_range(0, 1) == 1) wr(4 * idx, $urandom, 4'($urandom_range(1, 15)));
      else rd(4 * idx, d);
    end

    // Run 1: stale ready drops 5 cycles after kick, rises 100 later with scores 3k.
    for (int k = 0; k < NC; k++) sc[k*32 +: 32] = 32'(3 * k);
    accel_ready = 1'b1;
    fork
      accel_run(5, 100, 1'b0, sc);
      begin
        wr(32'h1000, 32'h1, 4'hF);
        rd(32'h1004, d);
        chk("status_busy", d, 32'h1);
        wr(32'h1000, 32'h1, 4'hF);
        wr(4 * 7, 32'hDEAD_BEEF, 4'hF);
        poll(32'h2, 400, d);
      end
    join
    chk("status_done", d, 32'h2);
    for (int k = 0; k < NC; k++) begin
      rd(32'h1010 + 4 * k, d);
      chk("result_3k", d, 32'(3 * k));
    end
    accel_results = {NC{$urandom}};
    repeat (5) @(negedge clk);
    rd(32'h1010 + 4 * 9, d);
    chk("result_held", d, 32'd27);

    // Run 2: ready never rises -> timeout error, results unchanged.
    fork
      accel_run(3, 0, 1'b1, sc);
      begin
        wr(32'h1000, 32'h1, 4'hF);
        poll(32'h4, 1500, d);
      end
    join
    chk("status_timeout", d, 32'h4);
    rd(32'h1010 + 4 * 5, d);
    chk("result_after_timeout", d, 32'd15);

    // Run 3: clear error and start together, random signed scores.
    for (int k = 0; k < NC; k++) sc[k*32 +: 32] = $urandom;
    fork
      accel_run(4, 60, 1'b0, sc);
      begin
        wr(32'h1000, 32'h3, 4'hF);
        rd(32'h1004, d);
        chk("status_clr_start", d, 32'h1);
        poll(32'h2, 400, d);
      end
    join
    chk("status_done2", d, 32'h2);
    for (int k = 0; k < NC; k++) rd(32'h1010 + 4 * k, d);
    rd(32'h1040, d);

    // Run 4: tie between classes 1 and 2, lowest index wins.
    sc = '0;
    sc[31:0]  = 32'hFFFF_FFFB;
    sc[63:32] = 32'd7;
    sc[95:64] = 32'd7;
    fork
      accel_run(2, 30, 1'b0, sc);
      begin
        wr(32'h1000, 32'h1, 4'hF);
        poll(32'h2, 400, d);
      end
    join
    rd(32'h1040, d);
`ifdef ACCEL_ARGMAX_EN
    chk("argmax_tie", d, 32'd1);
`else
    chk("argmax_absent", d, 32'd0);
`endif

    // Run 5: reset while waiting for ready to rise.
    fork
      accel_run(2, 0, 1'b1, sc);
      begin
        wr(32'h1000, 32'h1, 4'hF);
        repeat (20) @(negedge clk);
      end
    join
    #2 resetn = 1'b0;
    @(negedge clk);
    chk("midrun_reset_accel_reset", 32'(accel_reset), 32'd0);
    #2 resetn = 1'b1;
    @(negedge clk);
    rd(32'h1004, d);
    chk("status_after_reset", d, 32'd0);
    rd(32'h1010 + 4 * 1, d);
    chk("result_after_reset", d, 32'd0);
    rd(0, d);
    chk("image_after_reset", d, 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
